// File: rtl/syn_pcm_xfr_slave_buf.sv
// syn_pcm_xfr_slave_buf: PCM handshake slave feeding a show-ahead sample FIFO; SYN_PCM_XFR_STATS_EN adds saturating stats counters.
module syn_pcm_xfr_slave_buf #(
  parameter int PCM_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic               clk_ir,
  input  logic               rst_il,
  input  logic               pcm_data_valid,
  input  logic [2*PCM_W-1:0] pcm_data,
  output logic               ack,
  output logic               fifo_empty_o,
  output logic               fifo_full_o,
  output logic [PTR_W:0]     fifo_occ_o,
  output logic [2*PCM_W-1:0] fifo_data_o,
  input  logic               fifo_rd_i,
  output logic [15:0]        samples_cnt_o,
  output logic [15:0]        stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
  state_t state, state_nxt;
  logic [2*PCM_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] occ_nxt;
  logic wr, rd;
  // full comes from the registered occupancy, so a pop while full cannot admit a write that cycle
  assign wr = state == IDLE && pcm_data_valid && !fifo_full_o;
  assign rd = fifo_rd_i && !fifo_empty_o;
  always_ff @(posedge clk_ir)
    if (rst_il) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (wr ? ACK : IDLE) :
                state == ACK  ? WAIT_LOW :
                (pcm_data_valid ? WAIT_LOW : IDLE);
  always_comb
    ack = state == ACK;
  always_comb
    occ_nxt = wr && !rd ? fifo_occ_o + (PTR_W+1)'(1) :
              rd && !wr ? fifo_occ_o - (PTR_W+1)'(1) : fifo_occ_o;
  always_ff @(posedge clk_ir)
    if (rst_il) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_occ_o   <= '0;
      fifo_empty_o <= 1'b1;
      fifo_full_o  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_occ_o   <= occ_nxt;
      fifo_empty_o <= occ_nxt == '0;
      fifo_full_o  <= occ_nxt == (PTR_W+1)'(FIFO_DEPTH);
    end
  always_ff @(posedge clk_ir)
    if (wr) mem[wr_ptr] <= pcm_data;
  assign fifo_data_o = fifo_empty_o ? '0 : mem[rd_ptr];
`ifdef SYN_PCM_XFR_STATS_EN
  always_ff @(posedge clk_ir)
    if (rst_il) begin
      samples_cnt_o <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (ack && ~&samples_cnt_o) samples_cnt_o <= samples_cnt_o + 16'd1;
      if (state == IDLE && pcm_data_valid && fifo_full_o && ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`else
  assign samples_cnt_o = '0;
  assign stall_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_syn_pcm_xfr_slave_buf.sv
// tb_syn_pcm_xfr_slave_buf: vector table plus scoreboard sequences for the PCM slave buffer.
module tb_syn_pcm_xfr_slave_buf;
  logic clk = 0, rst = 1, pcm_data_valid = 0, fifo_rd_i = 0;
  logic [31:0] pcm_data = '0;
  logic ack, fifo_empty_o, fifo_full_o;
  logic [3:0] fifo_occ_o;
  logic [31:0] fifo_data_o;
  logic [15:0] samples_cnt_o, stall_cnt_o;
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  typedef struct {int n; logic v; logic [31:0] d; logic rd; logic ack; logic [3:0] occ; logic empty; logic full; logic [31:0] data;} vec_t;
  vec_t tbl[9];
  syn_pcm_xfr_slave_buf dut (
    .clk_ir(clk), .rst_il(rst), .pcm_data_valid(pcm_data_valid), .pcm_data(pcm_data),
    .ack(ack), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o), .fifo_occ_o(fifo_occ_o),
    .fifo_data_o(fifo_data_o), .fifo_rd_i(fifo_rd_i), .samples_cnt_o(samples_cnt_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    pcm_data_valid = 0;
    fifo_rd_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    q.delete();
  endtask
  task automatic send(input logic [31:0] d);
    logic got;
    got = 0;
    @(negedge clk);
    pcm_data_valid = 1;
    pcm_data = d;
    q.push_back(d);
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1 got = ack;
    end
    chk("send_ack", got, 1);
    @(negedge clk);
    pcm_data_valid = 0;
    @(negedge clk);
  endtask
  task automatic pop();
    @(negedge clk);
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL pop_underflow act=empty_queue req=sample");
    end else chk("pop_data", fifo_data_o, q.pop_front());
    fifo_rd_i = 1;
    @(negedge clk);
    fifo_rd_i = 0;
  endtask
  initial begin
    logic got;
    int lat;
    tbl[0] = '{1, 1, 32'h1234ABCD, 0, 1, 1, 0, 0, 32'h1234ABCD};
    tbl[1] = '{1, 1, 32'h1234ABCD, 0, 0, 1, 0, 0, 32'h1234ABCD};
    tbl[2] = '{9, 1, 32'h1234ABCD, 0, 0, 1, 0, 0, 32'h1234ABCD};
    tbl[3] = '{1, 0, 32'h0,        0, 0, 1, 0, 0, 32'h1234ABCD};
    tbl[4] = '{1, 1, 32'h5555AAAA, 0, 1, 2, 0, 0, 32'h1234ABCD};
    tbl[5] = '{1, 0, 32'h0,        0, 0, 2, 0, 0, 32'h1234ABCD};
    tbl[6] = '{1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h5555AAAA};
    tbl[7] = '{1, 0, 32'h0,        1, 0, 0, 1, 0, 32'h0};
    tbl[8] = '{1, 0, 32'h0,        1, 0, 0, 1, 0, 32'h0};
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_empty", fifo_empty_o, 1);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_occ", fifo_occ_o, 0);
    chk("rst_data", fifo_data_o, 0);
    chk("rst_samples", samples_cnt_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    rst = 0;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < tbl[i].n; j++) begin
        @(negedge clk);
        pcm_data_valid = tbl[i].v;
        pcm_data = tbl[i].d;
        fifo_rd_i = tbl[i].rd;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_ack", i), ack, tbl[i].ack);
        chk($sformatf("vec%0d_occ", i), fifo_occ_o, tbl[i].occ);
        chk($sformatf("vec%0d_empty", i), fifo_empty_o, tbl[i].empty);
        chk($sformatf("vec%0d_full", i), fifo_full_o, tbl[i].full);
        chk($sformatf("vec%0d_data", i), fifo_data_o, tbl[i].data);
      end
    do_reset();
    for (int k = 0; k < 8; k++) send(32'(k));
    chk("fill_full", fifo_full_o, 1);
    chk("fill_occ", fifo_occ_o, 8);
    @(negedge clk);
    pcm_data_valid = 1;
    pcm_data = 32'h8;
    q.push_back(32'h8);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("stall_ack", ack, 0);
      chk("stall_occ", fifo_occ_o, 8);
    end
    @(negedge clk);
`ifdef SYN_PCM_XFR_STATS_EN
    chk("stats_samples", samples_cnt_o, 8);
    chk("stats_stall", stall_cnt_o, 4);
`else
    chk("stats_samples", samples_cnt_o, 0);
    chk("stats_stall", stall_cnt_o, 0);
`endif
    chk("full_head", fifo_data_o, q.pop_front());
    fifo_rd_i = 1;
    got = 0;
    lat = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk);
      #1 fifo_rd_i = 0;
      lat++;
      got = ack;
    end
    chk("fill_ack_seen", got, 1);
    chk("fill_ack_lat_ge2", lat >= 2, 1);
    @(negedge clk);
    pcm_data_valid = 0;
    @(negedge clk);
    chk("refill_occ", fifo_occ_o, 8);
    for (int k = 0; k < 8; k++) pop();
    chk("drain_empty", fifo_empty_o, 1);
    do_reset();
    for (int k = 0; k < 3; k++) send(32'hC0DE_0000 + 32'(k));
    @(negedge clk);
    chk("simul_head", fifo_data_o, q.pop_front());
    pcm_data_valid = 1;
    pcm_data = 32'hA5A5_5A5A;
    q.push_back(32'hA5A5_5A5A);
    fifo_rd_i = 1;
    @(posedge clk);
    #1;
    chk("simul_occ", fifo_occ_o, 3);
    chk("simul_ack", ack, 1);
    @(negedge clk);
    fifo_rd_i = 0;
    pcm_data_valid = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) pop();
    @(negedge clk);
    fifo_rd_i = 1;
    @(posedge clk);
    #1;
    chk("empty_pop_occ", fifo_occ_o, 0);
    chk("empty_pop_empty", fifo_empty_o, 1);
    @(negedge clk);
    fifo_rd_i = 0;
    send(32'h0BAD_F00D);
    pop();
    do_reset();
    for (int k = 0; k < 4; k++) send(32'h100 + 32'(k));
    @(negedge clk);
    pcm_data_valid = 1;
    pcm_data = 32'h0000_0055;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1 got = ack;
    end
    chk("mid_ack", got, 1);
    chk("mid_occ", fifo_occ_o, 5);
    @(negedge clk);
    rst = 1;
    q.delete();
    @(posedge clk);
    #1;
    chk("midrst_ack", ack, 0);
    chk("midrst_occ", fifo_occ_o, 0);
    chk("midrst_empty", fifo_empty_o, 1);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("post_rst_ack", ack, 1);
    chk("post_rst_occ", fifo_occ_o, 1);
    chk("post_rst_data", fifo_data_o, 32'h55);
    @(negedge clk);
    pcm_data_valid = 0;
    @(negedge clk);
    q.push_back(32'h55);
    pop();
    @(negedge clk);
    chk("final_empty", fifo_empty_o, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
